// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
//   rv32_mem_size_t : access size encoding (2'b11 is illegal and has no member)
//   rv32_dmem_req_t : request payload {write, addr, size, wdata}
//   rv32_dmem_rsp_t : response payload {rdata, err}
//   DMEM_LAT_W      : latency counter width (covers LATENCY up to 15)
package dmem_responder_pkg;

   localparam int unsigned DMEM_LAT_W = 4;

   typedef enum logic [1:0] {
      MEM_B = 2'b00,
      MEM_H = 2'b01,
      MEM_W = 2'b10
   } rv32_mem_size_t;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
   } rv32_dmem_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rv32_dmem_rsp_t;

   // Byte-lane write strobe for a legal access at byte offset off.
   function automatic logic [3:0] lane_strobe(logic [1:0] size, logic [1:0] off);
      case (size)
         MEM_B:   return 4'b0001 << off;
         MEM_H:   return 4'b0011 << off;
         MEM_W:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Replicate right-aligned store data into every lane it may land in.
   function automatic logic [31:0] lane_wdata(logic [1:0] size, logic [31:0] wdata);
      case (size)
         MEM_B:   return {4{wdata[7:0]}};
         MEM_H:   return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   // Illegal size or natural-alignment violation.
   function automatic logic size_misaligned(logic [1:0] size, logic [1:0] off);
      case (size)
         MEM_B:   return 1'b0;
         MEM_H:   return off[0];
         MEM_W:   return |off;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory access interface between the memory stage (master) and the
// responder (slave).
//   req_valid/req_ready : request handshake
//   req_write/addr/size/wdata : request payload
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata/rsp_err   : response payload
interface dmem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_array.sv
// Single-port word-organised RAM built from four byte-lane synchronous RAMs.
//   clk   : clock
//   en    : access enable; read data updates only on enabled edges
//   we    : per-lane write enable
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (old contents on read-during-write)
module dmem_array #(
   parameter int unsigned DEPTH_WORDS = 1024,
   localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] q;

      // Contents are intentionally not reset.
      always_ff @(posedge clk) begin
         if (en) begin
            if (we[l]) begin
               mem[addr] <= wdata[8*l +: 8];
            end
            q <= mem[addr];
         end
      end

      assign rdata[8*l +: 8] = q;
   end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the data-memory access interface. Accepts one load/store
// at a time, performs a strobed write or aligned read on the RAM at the accept
// edge, and returns the response LATENCY edges later, holding it until taken.
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : dmem_responder_if slave modport (request and response channels)
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic             clk,
   input  logic             resetn,
   dmem_responder_if.slave  bus
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [DMEM_LAT_W-1:0] cnt_q, cnt_d;
   logic                  ready_q, ready_d;
   logic                  valid_q, valid_d;
   rv32_dmem_rsp_t        rsp_q, rsp_d;
   logic                  wr_q, wr_d;
   logic                  err_q, err_d;
   logic [1:0]            off_q, off_d;

   rv32_dmem_req_t        req_c;
   logic                  accept_c;
   logic                  in_range_c;
   logic                  err_c;
   logic                  ram_en_c;
   logic [3:0]            ram_we_c;
   logic [AW-1:0]         ram_addr_c;
   logic [31:0]           ram_wdata_c;
   logic [31:0]           ram_rdata;

   // Request decode: strobes, replicated data and error classification.
   always_comb begin
      req_c       = '{write: bus.req_write, addr: bus.req_addr,
                      size: bus.req_size, wdata: bus.req_wdata};
      accept_c    = (state_q == S_IDLE) && ready_q && bus.req_valid;
      in_range_c  = {2'b00, req_c.addr[31:2]} < 32'(DEPTH_WORDS);
      err_c       = size_misaligned(req_c.size, req_c.addr[1:0]) || !in_range_c;
      ram_en_c    = accept_c;
      ram_we_c    = (accept_c && req_c.write && !err_c)
                    ? lane_strobe(req_c.size, req_c.addr[1:0]) : 4'b0000;
      ram_addr_c  = req_c.addr[AW+1:2];
      ram_wdata_c = lane_wdata(req_c.size, req_c.wdata);
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk   (clk),
      .en    (ram_en_c),
      .we    (ram_we_c),
      .addr  (ram_addr_c),
      .wdata (ram_wdata_c),
      .rdata (ram_rdata)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      valid_d = valid_q;
      rsp_d   = rsp_q;
      wr_d    = wr_q;
      err_d   = err_q;
      off_d   = off_q;

      case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            if (accept_c) begin
               ready_d = 1'b0;
               wr_d    = req_c.write;
               err_d   = err_c;
               off_d   = req_c.addr[1:0];
               if (LATENCY > 1) begin
                  state_d = S_WAIT;
                  cnt_d   = DMEM_LAT_W'(LATENCY - 2);
               end else begin
                  state_d = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - DMEM_LAT_W'(1);
            end
         end
         S_RESP: begin
            // First RESP cycle loads the response; RAM output is held since accept.
            if (!valid_q) begin
               valid_d    = 1'b1;
               rsp_d.err  = err_q;
               rsp_d.rdata = (wr_q || err_q) ? 32'h0 : (ram_rdata >> {off_q, 3'b000});
            end else if (bus.rsp_ready) begin
               valid_d = 1'b0;
               rsp_d   = '0;
               ready_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            ready_d = 1'b0;
            valid_d = 1'b0;
            rsp_d   = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         rsp_q   <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         off_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         rsp_q   <= rsp_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         off_q   <= off_d;
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = valid_q;
   assign bus.rsp_rdata = rsp_q.rdata;
   assign bus.rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table of load/store vectors with
// expected responses pushed to a scoreboard at accept and popped at response,
// plus hand sequences for reset release, backpressure and reset mid-transaction.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned LAT   = 2;
   localparam int unsigned BOUND = 50;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   acc_cyc = 0;
   int   prev_acc = 0;

   vec_t vecs[$];
   exp_t sb[$];

   dmem_responder_if bus();

   dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic add_vec(input logic w, input logic [31:0] a, input logic [1:0] s,
                          input logic [31:0] d, input logic [31:0] er, input logic ee);
      vec_t v;
      v.write = w; v.addr = a; v.size = s; v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
      vecs.push_back(v);
   endtask

   // Present a request at the current negedge and wait for its accept edge.
   task automatic start_req(input logic w, input logic [31:0] a, input logic [1:0] s,
                            input logic [31:0] d, output bit ok);
      int n;
      ok = 1'b0;
      bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a;
      bus.req_size = s; bus.req_wdata = d;
      n = 0;
      while (!bus.req_ready && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         checks++; failures++;
         $display("FAIL accept_timeout actual=no_ready required=ready");
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      prev_acc = acc_cyc;
      acc_cyc  = cyc;
      ok = 1'b1;
   endtask

   // Wait (bounded) for rsp_valid, returning at the negedge where it is first seen.
   task automatic wait_rsp(output bit ok);
      int n;
      ok = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.rsp_valid && n < BOUND);
      if (!bus.rsp_valid) begin
         checks++; failures++;
         $display("FAIL rsp_timeout actual=no_valid required=valid");
         return;
      end
      ok = 1'b1;
   endtask

   task automatic txn(input vec_t v, input int idx, input bit chk_gap);
      bit   ok;
      exp_t e;
      start_req(v.write, v.addr, v.size, v.wdata, ok);
      if (!ok) return;
      sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
      if (chk_gap) chk($sformatf("accept_gap[%0d]", idx), 32'(acc_cyc - prev_acc), 32'(LAT + 2));
      wait_rsp(ok);
      if (!ok) return;
      chk($sformatf("latency[%0d]", idx), 32'(cyc - acc_cyc), 32'(LAT));
      e = sb.pop_front();
      chk($sformatf("rdata[%0d]", idx), bus.rsp_rdata, e.rdata);
      chk($sformatf("err[%0d]", idx), 32'(bus.rsp_err), 32'(e.err));
   endtask

   initial begin
      logic [31:0] held;
      bit ok;
      vec_t v;

      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
      bus.req_size = 2'b00; bus.req_wdata = '0; bus.rsp_ready = 1'b1;

      // write addr size wdata exp_rdata exp_err
      add_vec(1, 32'h10,   2'b10, 32'hDEADBEEF, 32'h0, 0);
      add_vec(0, 32'h13,   2'b00, 32'h0,        32'h000000DE, 0);
      add_vec(0, 32'h10,   2'b00, 32'h0,        32'hDEADBEEF, 0);
      add_vec(0, 32'h12,   2'b01, 32'h0,        32'h0000DEAD, 0);
      add_vec(1, 32'h20,   2'b10, 32'hAABBCCDD, 32'h0, 0);
      add_vec(1, 32'h22,   2'b01, 32'hFFFF1234, 32'h0, 0);
      add_vec(0, 32'h20,   2'b10, 32'h0,        32'h1234CCDD, 0);
      add_vec(1, 32'h21,   2'b00, 32'hFFFFFF5A, 32'h0, 0);
      add_vec(0, 32'h20,   2'b10, 32'h0,        32'h12345ADD, 0);
      add_vec(0, 32'h05,   2'b10, 32'h0,        32'h0, 1);
      add_vec(1, 32'h04,   2'b10, 32'hCAFEF00D, 32'h0, 0);
      add_vec(1, 32'h07,   2'b01, 32'h00009999, 32'h0, 1);
      add_vec(0, 32'h04,   2'b10, 32'h0,        32'hCAFEF00D, 0);
      add_vec(1, 32'h00,   2'b10, 32'h01020304, 32'h0, 0);
      add_vec(1, 32'h1000, 2'b10, 32'h55555555, 32'h0, 1);
      add_vec(0, 32'h00,   2'b10, 32'h0,        32'h01020304, 0);
      add_vec(0, 32'h1000, 2'b10, 32'h0,        32'h0, 1);
      add_vec(0, 32'h10,   2'b11, 32'h0,        32'h0, 1);
      add_vec(0, 32'h11,   2'b01, 32'h0,        32'h0, 1);
      add_vec(1, 32'h13,   2'b00, 32'h00000077, 32'h0, 0);
      add_vec(0, 32'h10,   2'b10, 32'h0,        32'h77ADBEEF, 0);
      add_vec(0, 32'h02,   2'b01, 32'h0,        32'h00000102, 0);
      add_vec(1, 32'h00,   2'b11, 32'hFFFFFFFF, 32'h0, 1);
      add_vec(0, 32'h00,   2'b10, 32'h0,        32'h01020304, 0);

      // Reset values and release.
      repeat (3) @(negedge clk);
      chk("reset_req_ready", 32'(bus.req_ready), 32'h0);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("reset_rsp_err",   32'(bus.rsp_err), 32'h0);
      resetn = 1'b1;
      #1;
      chk("release_req_ready_low", 32'(bus.req_ready), 32'h0);
      @(negedge clk);
      chk("release_req_ready_high", 32'(bus.req_ready), 32'h1);
      repeat (3) begin
         @(negedge clk);
         chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      end

      // Back-to-back table with rsp_ready held high.
      for (int i = 0; i < vecs.size(); i++) begin
         txn(vecs[i], i, i > 0);
      end
      @(negedge clk);

      // Backpressure: response held, new request ignored.
      bus.rsp_ready = 1'b0;
      start_req(1'b0, 32'h20, 2'b10, 32'h0, ok);
      if (ok) begin
         wait_rsp(ok);
         if (ok) begin
            held = bus.rsp_rdata;
            chk("bp_first_rdata", held, 32'h12345ADD);
            bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h20;
            bus.req_size = 2'b10; bus.req_wdata = 32'hFFFFFFFF;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
               chk("bp_rsp_rdata", bus.rsp_rdata, held);
               chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
            end
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            chk("bp_released_valid", 32'(bus.rsp_valid), 32'h0);
         end
      end
      bus.rsp_ready = 1'b1;
      v.write = 0; v.addr = 32'h20; v.size = 2'b10; v.wdata = 0;
      v.exp_rdata = 32'h12345ADD; v.exp_err = 0;
      txn(v, 100, 1'b0);
      @(negedge clk);

      // Reset in WAIT after a committed store: no response, store retained.
      start_req(1'b1, 32'h30, 2'b10, 32'h0BADCAFE, ok);
      if (ok) begin
         @(negedge clk);
         resetn = 1'b0;
         #1;
         chk("rst_wait_req_ready", 32'(bus.req_ready), 32'h0);
         chk("rst_wait_rsp_valid", 32'(bus.rsp_valid), 32'h0);
         repeat (2) @(negedge clk);
         resetn = 1'b1;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst_after_rsp_valid", 32'(bus.rsp_valid), 32'h0);
         end
         chk("rst_after_req_ready", 32'(bus.req_ready), 32'h1);
      end
      v.write = 0; v.addr = 32'h30; v.size = 2'b10; v.wdata = 0;
      v.exp_rdata = 32'h0BADCAFE; v.exp_err = 0;
      txn(v, 101, 1'b0);
      @(negedge clk);
      v.addr = 32'h10; v.exp_rdata = 32'h77ADBEEF;
      txn(v, 102, 1'b0);

      chk("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
